// File: rtl/adc_pkg.sv
// Shared definitions for the SPI ADC responder: conversion width, config
// bit positions inside the captured {SGL, ODD, MSBF} word and the FSM states.
package adc_pkg;

  localparam int DATA_W = 10;

  // Positions inside the 3-bit config word, shifted in SGL first.
  localparam int CFG_SGL  = 2;
  localparam int CFG_ODD  = 1;
  localparam int CFG_MSBF = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CFG,
    ST_NULL,
    ST_MSB,
    ST_LSB,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adc_responder_if.sv
// Serial pins between the audio-path ADC master and the ADC responder.
interface adc_responder_if;

  logic adc_cs;
  logic adc_clk;
  logic adc_din;
  logic adc_dout;
  logic adc_dout_en;

  modport master (
    output adc_cs,
    output adc_clk,
    output adc_din,
    input  adc_dout,
    input  adc_dout_en
  );

  modport slave (
    input  adc_cs,
    input  adc_clk,
    input  adc_din,
    output adc_dout,
    output adc_dout_en
  );

endinterface

// File: rtl/sync_edge.sv
// N-stage synchroniser for an asynchronous pin plus rise/fall detection
// on the synchronised value. Edge flags are combinational from two flops.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchroniser and keep one extra history flop.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the value from before the clock edge, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;

endmodule

// File: rtl/adc_responder.sv
// Serial-slave model of a 2-channel SPI ADC. Oversamples cs/sclk/din with
// the system clock, decodes start + {SGL, ODD, MSBF}, then shifts out a
// null bit and the conversion MSB-first (optionally followed by an
// LSB-first replay of B1..B9).
module adc_responder #(
  parameter int DATA_W      = adc_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_responder_if.slave    spi,
  input  logic [DATA_W-1:0] ch0_sample,
  input  logic [DATA_W-1:0] ch1_sample,
  output logic              sample_taken,
  output logic [1:0]        sample_cfg,
  output logic              frame_err
);

  import adc_pkg::*;

  // Synchronised pins and edge flags.
  logic cs_s, cs_fall, cs_rise_unused;
  logic sclk_rise, sclk_fall, sclk_s_unused;
  logic din_s, din_rise_unused, din_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.adc_cs),
    .q     (cs_s),
    .rise  (cs_rise_unused),
    .fall  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.adc_clk),
    .q     (sclk_s_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.adc_din),
    .q     (din_s),
    .rise  (din_rise_unused),
    .fall  (din_fall_unused)
  );

  // Registered state and its next-state values.
  state_e            state_q, state_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        cfg_q, cfg_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic              taken_q, taken_d;
  logic [1:0]        scfg_q, scfg_d;
  logic              ferr_q, ferr_d;

  logic [3:0]        bit_inc;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] conv_value;

  // Bit index saturates instead of wrapping.
  assign bit_inc = (bit_idx_q == 4'hF) ? bit_idx_q : bit_idx_q + 4'd1;

  // Conversion value from the captured config; differential results are
  // formed one bit wider so a borrow shows up as a negative result to clamp.
  assign diff = cfg_q[CFG_ODD] ? ({1'b0, ch1_sample} - {1'b0, ch0_sample})
                               : ({1'b0, ch0_sample} - {1'b0, ch1_sample});
  assign conv_value = cfg_q[CFG_SGL] ? (cfg_q[CFG_ODD] ? ch1_sample : ch0_sample)
                                     : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      cfg_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= 1'b0;
      dout_en_q <= 1'b0;
      taken_q   <= 1'b0;
      scfg_q    <= 2'b00;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cfg_q     <= cfg_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      taken_q   <= taken_d;
      scfg_q    <= scfg_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state and output decode; a cs rise overrides any serial edge.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cfg_d     = cfg_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    dout_en_d = dout_en_q;
    taken_d   = 1'b0;
    scfg_d    = scfg_q;
    ferr_d    = 1'b0;

    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
      dout_d    = 1'b0;
      dout_en_d = 1'b0;
      if (state_q inside {ST_CFG, ST_NULL, ST_MSB, ST_LSB}) ferr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_idx_d = '0;
          dout_d    = 1'b0;
          dout_en_d = 1'b0;
          if (cs_fall) state_d = ST_START;
        end
        ST_START: begin
          // Leading zeros are skipped until the start bit arrives.
          if (sclk_rise && din_s) begin
            state_d   = ST_CFG;
            bit_idx_d = '0;
          end
        end
        ST_CFG: begin
          if (sclk_rise) begin
            cfg_d = {cfg_q[1:0], din_s};
            if (bit_idx_q == 4'd2) begin
              state_d   = ST_NULL;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_inc;
            end
          end
        end
        ST_NULL: begin
          if (sclk_fall) begin
            shreg_d   = conv_value;
            taken_d   = 1'b1;
            scfg_d    = {cfg_q[CFG_SGL], cfg_q[CFG_ODD]};
            dout_en_d = 1'b1;
            dout_d    = 1'b0;
            state_d   = ST_MSB;
            bit_idx_d = '0;
          end
        end
        ST_MSB: begin
          // Rotate left: after DATA_W shifts the register holds the
          // original value again, ready for the LSB-first replay.
          if (sclk_fall) begin
            dout_d  = shreg_q[DATA_W-1];
            shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
            if (bit_idx_q == 4'(DATA_W - 1)) begin
              state_d   = cfg_q[CFG_MSBF] ? ST_DONE : ST_LSB;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_inc;
            end
          end
        end
        ST_LSB: begin
          // Rotate right, presenting B1 first and B9 last.
          if (sclk_fall) begin
            dout_d  = shreg_q[1];
            shreg_d = {shreg_q[0], shreg_q[DATA_W-1:1]};
            if (bit_idx_q == 4'(DATA_W - 2)) begin
              state_d   = ST_DONE;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_inc;
            end
          end
        end
        ST_DONE: begin
          // Hold the last data bit until the master's next fall.
          if (sclk_fall) dout_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign spi.adc_dout    = dout_q;
  assign spi.adc_dout_en = dout_en_q;
  assign sample_taken    = taken_q;
  assign sample_cfg      = scfg_q;
  assign frame_err       = ferr_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: behaves as the SPI master, pushes the expected
// serial bits of each frame into a queue and pops one per master sample.
module tb_adc_responder;

  localparam int DW   = 10;
  localparam int HALF = 5;   // sclk half period in clk cycles

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] ch0, ch1;
  logic          sample_taken;
  logic [1:0]    sample_cfg;
  logic          frame_err;

  adc_responder_if spi ();

  adc_responder #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi),
    .ch0_sample   (ch0),
    .ch1_sample   (ch1),
    .sample_taken (sample_taken),
    .sample_cfg   (sample_cfg),
    .frame_err    (frame_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling clk edge.
  int         st_cnt = 0;
  int         fe_cnt = 0;
  logic [1:0] last_cfg = 2'b00;

  always @(negedge clk) begin
    if (sample_taken === 1'b1) begin
      st_cnt++;
      last_cfg = sample_cfg;
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  logic expq[$];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model(input logic sgl, input logic odd,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    int d;
    if (sgl) return odd ? b : a;
    d = odd ? (int'(b) - int'(a)) : (int'(a) - int'(b));
    if (d < 0) d = 0;
    return DW'(d);
  endfunction

  // One master frame. stop_period >= 0 ends the frame right after that
  // period's sample, leaving cs low for the caller to abort or reset.
  task automatic run_frame(input int lead, input logic sgl, input logic odd,
                           input logic msbf, input int stop_period, input string tag);
    logic [DW-1:0] conv;
    int            nper;
    logic          b;
    logic          e;
    conv = model(sgl, odd, ch0, ch1);
    nper = msbf ? lead + 15 : lead + 24;
    expq.delete();
    expq.push_back(1'b0);
    for (int i = DW - 1; i >= 0; i--) expq.push_back(conv[i]);
    if (!msbf) for (int j = 1; j < DW; j++) expq.push_back(conv[j]);

    spi.adc_cs  = 1'b0;
    spi.adc_din = 1'b0;
    for (int p = 0; p < nper; p++) begin
      spi.adc_clk = 1'b0;
      if (p < lead)          b = 1'b0;
      else if (p == lead)    b = 1'b1;
      else if (p == lead+1)  b = sgl;
      else if (p == lead+2)  b = odd;
      else if (p == lead+3)  b = msbf;
      else                   b = 1'b0;
      spi.adc_din = b;
      wait_clk(HALF);
      spi.adc_clk = 1'b1;
      if (p >= lead + 4) begin
        e = expq.pop_front();
        check({tag, " dout"}, 32'(spi.adc_dout), 32'(e));
        check({tag, " en"}, 32'(spi.adc_dout_en), 32'd1);
      end
      // Scramble the channels once the value is latched.
      if (p == lead + 5) begin
        ch0 = DW'($urandom);
        ch1 = DW'($urandom);
      end
      if (p == stop_period) return;
      wait_clk(HALF);
    end
    // One more fall: DONE drives zero while still enabled.
    spi.adc_clk = 1'b0;
    wait_clk(HALF);
    check({tag, " done dout"}, 32'(spi.adc_dout), 32'd0);
    check({tag, " done en"}, 32'(spi.adc_dout_en), 32'd1);
    spi.adc_cs = 1'b1;
    wait_clk(HALF);
    check({tag, " idle en"}, 32'(spi.adc_dout_en), 32'd0);
  endtask

  // Full frame with pulse bookkeeping around it.
  task automatic full_frame(input int lead, input logic sgl, input logic odd,
                            input logic msbf, input string tag);
    int st0, fe0;
    st0 = st_cnt;
    fe0 = fe_cnt;
    run_frame(lead, sgl, odd, msbf, -1, tag);
    check({tag, " taken cnt"}, 32'(st_cnt - st0), 32'd1);
    check({tag, " cfg pulse"}, 32'(last_cfg), 32'({sgl, odd}));
    check({tag, " cfg out"}, 32'(sample_cfg), 32'({sgl, odd}));
    check({tag, " ferr cnt"}, 32'(fe_cnt - fe0), 32'd0);
    wait_clk(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    rst_n       = 1'b0;
    spi.adc_cs  = 1'b1;
    spi.adc_clk = 1'b0;
    spi.adc_din = 1'b0;
    ch0         = '0;
    ch1         = '0;
    wait_clk(3);
    check("rst dout",  32'(spi.adc_dout),    32'd0);
    check("rst en",    32'(spi.adc_dout_en), 32'd0);
    check("rst taken", 32'(sample_taken),    32'd0);
    check("rst cfg",   32'(sample_cfg),      32'd0);
    check("rst ferr",  32'(frame_err),       32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Single-ended CH0, MSB first.
    ch0 = 10'h2A5; ch1 = 10'h0F0;
    full_frame(0, 1'b1, 1'b0, 1'b1, "se_ch0");

    // Single-ended CH1, LSB replay.
    ch0 = 10'h0AA; ch1 = 10'h301;
    full_frame(0, 1'b1, 1'b1, 1'b0, "lsb_ch1");

    // Differential: negative clamps to zero, then the positive direction.
    ch0 = 10'd100; ch1 = 10'd300;
    full_frame(0, 1'b0, 1'b0, 1'b1, "diff_clamp");
    ch0 = 10'd100; ch1 = 10'd300;
    full_frame(0, 1'b0, 1'b1, 1'b1, "diff_pos");

    // Leading zeros before the start bit.
    ch0 = 10'h3FF; ch1 = 10'h000;
    full_frame(3, 1'b1, 1'b0, 1'b1, "lead0");

    // Abort after B5 has been driven (B9 at period 5 .. B5 at period 9).
    ch0 = 10'h2C6; ch1 = 10'h111;
    fe0 = fe_cnt;
    run_frame(0, 1'b1, 1'b0, 1'b1, 9, "abort");
    spi.adc_cs  = 1'b1;
    spi.adc_clk = 1'b0;
    wait_clk(3);
    check("abort en", 32'(spi.adc_dout_en), 32'd0);
    wait_clk(4);
    check("abort ferr cnt", 32'(fe_cnt - fe0), 32'd1);
    ch0 = 10'h1C3; ch1 = 10'h222;
    full_frame(0, 1'b1, 1'b0, 1'b1, "post_abort");

    // Asynchronous reset in the middle of the MSB phase.
    ch0 = 10'h0F0; ch1 = 10'h3A5;
    run_frame(0, 1'b1, 1'b1, 1'b1, 7, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    check("mid rst dout",  32'(spi.adc_dout),    32'd0);
    check("mid rst en",    32'(spi.adc_dout_en), 32'd0);
    check("mid rst taken", 32'(sample_taken),    32'd0);
    check("mid rst cfg",   32'(sample_cfg),      32'd0);
    check("mid rst ferr",  32'(frame_err),       32'd0);
    spi.adc_cs  = 1'b1;
    spi.adc_clk = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(6);
    ch0 = 10'h2AA; ch1 = 10'h155;
    full_frame(0, 1'b1, 1'b1, 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
